// File: rtl/td4_core_pkg.sv
// Shared constants for the TD4 4-bit core: data width and the fixed opcode map.
package td4_core_pkg;

    localparam int WORD_W = 4;
    localparam int OP_W   = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [OP_W-1:0]   opcode_t;

    localparam opcode_t OP_ADD_A_IM = 4'b0000;
    localparam opcode_t OP_MOV_A_B  = 4'b0001;
    localparam opcode_t OP_IN_A     = 4'b0010;
    localparam opcode_t OP_MOV_A_IM = 4'b0011;
    localparam opcode_t OP_MOV_B_A  = 4'b0100;
    localparam opcode_t OP_ADD_B_IM = 4'b0101;
    localparam opcode_t OP_IN_B     = 4'b0110;
    localparam opcode_t OP_MOV_B_IM = 4'b0111;
    localparam opcode_t OP_OUT_B    = 4'b1001;
    localparam opcode_t OP_OUT_IM   = 4'b1011;
    localparam opcode_t OP_JNC_IM   = 4'b1110;
    localparam opcode_t OP_JMP_IM   = 4'b1111;

endpackage

// File: rtl/td4_core_alu4.sv
// Unsigned adder shared by both ADD instructions; cout feeds the carry flag.
module alu4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/td4_core.sv
// TD4 single-cycle core: ROM word decoded combinationally and executed on each enabled edge.
module td4_core
    import td4_core_pkg::*;
#(
    parameter logic [3:0] PC_RESET = 4'h0
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic       cpu_en,
    output logic [3:0] rom_adrs,
    input  logic [7:0] rom_dat,
    input  logic [3:0] in_port,
    output logic [3:0] out_port,
    output logic       halted
);

    word_t   pc_q, pc_d;
    word_t   a_q, a_d;
    word_t   b_q, b_d;
    word_t   out_q, out_d;
    logic    carry_q, carry_d;
    logic    halted_q, halted_d;

    opcode_t opcode;
    word_t   imm;
    word_t   alu_a;
    word_t   alu_sum;
    logic    alu_cout;

    assign opcode = rom_dat[7:4];
    assign imm    = rom_dat[3:0];

    // Only ADD B takes B as the adder operand; everything else routes A.
    assign alu_a = (opcode == OP_ADD_B_IM) ? b_q : a_q;

    alu4 #(.W(WORD_W)) u_alu (
        .a    (alu_a),
        .b    (imm),
        .sum  (alu_sum),
        .cout (alu_cout)
    );

    always_comb begin
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        carry_d  = carry_q;
        halted_d = halted_q;
        if (cpu_en) begin
            pc_d    = pc_q + 4'd1;
            carry_d = 1'b0;
            case (opcode)
                OP_ADD_A_IM: begin
                    a_d     = alu_sum;
                    carry_d = alu_cout;
                end
                OP_MOV_A_B:  a_d = b_q;
                OP_IN_A:     a_d = in_port;
                OP_MOV_A_IM: a_d = imm;
                OP_MOV_B_A:  b_d = a_q;
                OP_ADD_B_IM: begin
                    b_d     = alu_sum;
                    carry_d = alu_cout;
                end
                OP_IN_B:     b_d = in_port;
                OP_MOV_B_IM: b_d = imm;
                OP_OUT_B:    out_d = b_q;
                OP_OUT_IM:   out_d = imm;
                // JNC tests the carry left by the previous instruction.
                OP_JNC_IM: begin
                    if (!carry_q) pc_d = imm;
                end
                OP_JMP_IM: begin
                    pc_d = imm;
                    if (imm == pc_q) halted_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            pc_q     <= PC_RESET;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

    assign rom_adrs = pc_q;
    assign out_port = out_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_td4_core.sv
// Bench for td4_core: ISA-level reference model compared every cycle plus directed literal checks.
module tb_td4_core;

    logic       clk_cpu = 1'b0;
    logic       reset   = 1'b0;
    logic       cpu_en  = 1'b1;
    logic [3:0] rom_adrs;
    logic [7:0] rom_dat;
    logic [3:0] in_port = 4'h0;
    logic [3:0] out_port;
    logic       halted;

    logic [7:0] rom [16];
    logic       chk_on = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        int pc;
        int a;
        int b;
        int c;
        int outp;
        int h;
    } mstate_t;

    mstate_t m;

    td4_core #(.PC_RESET(4'h0)) dut (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .cpu_en   (cpu_en),
        .rom_adrs (rom_adrs),
        .rom_dat  (rom_dat),
        .in_port  (in_port),
        .out_port (out_port),
        .halted   (halted)
    );

    always #5 clk_cpu = ~clk_cpu;

    assign rom_dat = rom[rom_adrs];

    // Instruction-set reference: opcode number -> architectural effect.
    function automatic mstate_t isa_step(input mstate_t s, input int instr, input int inp);
        mstate_t n;
        int op, im, t;
        op = instr / 16;
        im = instr % 16;
        n = s;
        n.pc = (s.pc + 1) % 16;
        n.c = 0;
        case (op)
            0:  begin t = s.a + im; n.a = t % 16; n.c = t / 16; end
            1:  n.a = s.b;
            2:  n.a = inp;
            3:  n.a = im;
            4:  n.b = s.a;
            5:  begin t = s.b + im; n.b = t % 16; n.c = t / 16; end
            6:  n.b = inp;
            7:  n.b = im;
            9:  n.outp = s.b;
            11: n.outp = im;
            14: if (s.c == 0) n.pc = im;
            15: begin n.pc = im; if (im == s.pc) n.h = 1; end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            m <= '{pc: 0, a: 0, b: 0, c: 0, outp: 0, h: 0};
        end else if (cpu_en) begin
            m <= isa_step(m, int'(rom[m.pc]), int'(in_port));
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_cpu) begin
        if (chk_on) begin
            cmp("model rom_adrs", 32'(rom_adrs), 32'(m.pc));
            cmp("model out_port", 32'(out_port), 32'(m.outp));
            cmp("model halted",   32'(halted),   32'(m.h));
        end
    end

    task automatic hold_reset();
        @(negedge clk_cpu);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    endtask

    task automatic release_reset();
        @(negedge clk_cpu);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_cpu);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        repeat (2) @(negedge clk_cpu);
        chk_on = 1'b1;

        // Halt: OUT 5; JMP F; F: JMP F
        hold_reset();
        rom[0] = 8'hB5; rom[1] = 8'hFF; rom[15] = 8'hFF;
        release_reset();
        step(2);
        cmp("jmp to F pc", 32'(rom_adrs), 32'hF);
        cmp("jmp not self", 32'(halted), 32'h0);
        step(1);
        cmp("self jmp halted", 32'(halted), 32'h1);
        cmp("self jmp pc", 32'(rom_adrs), 32'hF);
        cmp("out before rst", 32'(out_port), 32'h5);

        // Asynchronous reset in the middle of the high phase
        @(posedge clk_cpu);
        #2 reset = 1'b0;
        #1;
        cmp("async rst out", 32'(out_port), 32'h0);
        cmp("async rst adrs", 32'(rom_adrs), 32'h0);
        cmp("async rst halted", 32'(halted), 32'h0);
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        rom[0] = 8'hB7;
        @(negedge clk_cpu);
        reset = 1'b1;
        @(posedge clk_cpu);
        #1;
        cmp("first edge out", 32'(out_port), 32'h7);
        cmp("first edge adrs", 32'(rom_adrs), 32'h1);

        // ADD A overflow, JNC falls through
        hold_reset();
        rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0;
        rom[3] = 8'h40; rom[4] = 8'h90; rom[5] = 8'hF5;
        release_reset();
        step(3);
        cmp("jnc fall pc", 32'(rom_adrs), 32'h3);
        step(2);
        cmp("add wrap A", 32'(out_port), 32'h1);
        step(1);
        cmp("halt at 5", 32'(halted), 32'h1);

        // ADD A without overflow, JNC taken
        hold_reset();
        rom[0] = 8'h33; rom[1] = 8'h01; rom[2] = 8'hE0;
        release_reset();
        step(3);
        cmp("jnc taken pc", 32'(rom_adrs), 32'h0);

        // Moves, I/O and a five-edge stall
        hold_reset();
        in_port = 4'hA;
        rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h51; rom[3] = 8'hE5;
        rom[4] = 8'hBF; rom[5] = 8'h90; rom[6] = 8'hF6;
        release_reset();
        step(2);
        cpu_en = 1'b0;
        step(5);
        cmp("stall pc", 32'(rom_adrs), 32'h2);
        cmp("stall out", 32'(out_port), 32'h0);
        cpu_en = 1'b1;
        step(2);
        cmp("add B no carry jnc", 32'(rom_adrs), 32'h5);
        step(1);
        cmp("out B", 32'(out_port), 32'hB);

        // ADD B overflow, IN B, MOV A,B, ADD A, MOV B,A, OUT B
        hold_reset();
        in_port = 4'h5;
        rom[0] = 8'h7F; rom[1] = 8'h51; rom[2] = 8'hE0; rom[3] = 8'h60;
        rom[4] = 8'h10; rom[5] = 8'h02; rom[6] = 8'h40; rom[7] = 8'h90;
        rom[8] = 8'hF8;
        release_reset();
        step(3);
        cmp("add B carry jnc", 32'(rom_adrs), 32'h3);
        step(5);
        cmp("chain out", 32'(out_port), 32'h7);

        // Undefined opcode clears carry so JNC is taken
        hold_reset();
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hA0; rom[3] = 8'hE7;
        rom[4] = 8'hC0; rom[7] = 8'hB9; rom[8] = 8'hF8;
        release_reset();
        step(4);
        cmp("undef clears carry", 32'(rom_adrs), 32'h7);
        step(1);
        cmp("out Im 9", 32'(out_port), 32'h9);

        // NOP at F wraps pc to 0
        hold_reset();
        rom[0] = 8'hFF; rom[15] = 8'hD0;
        release_reset();
        step(2);
        cmp("wrap pc", 32'(rom_adrs), 32'h0);
        cmp("wrap not halted", 32'(halted), 32'h0);
        step(3);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/td4_core.md
Name: td4_core

Overview:
- 4-bit single-cycle CPU core that reads and executes the 8-bit instruction stream held in the program ROM.
- Drives the ROM address from its program counter and decodes and executes the returned word in the same cycle.
- Holds registers A and B, a carry flag and a 4-bit output port, and samples a 4-bit input port.
- Sits between the ROM and the board I/O (switches in, LEDs out) in the FourBitCPU top level.

Parameters:
- PC_RESET, 4'h0, program counter value loaded on reset.

Ports:
- clk_cpu  input  1  CPU clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_en  input  1  clock enable; one instruction executes per clk_cpu edge while high.
- rom_adrs  output  4  instruction address to the ROM; equals the PC.
- rom_dat  input  8  instruction word from the ROM; combinational, valid in the same cycle. [7:4] is the opcode, [3:0] is the immediate.
- in_port  input  4  input port sampled by IN instructions.
- out_port  output  4  registered output port.
- halted  output  1  high once a JMP to its own address has executed.

Behaviour:
- Reset (reset==0, asynchronous): pc=PC_RESET, A=0, B=0, carry=0, out_port=0, halted=0. Reset mid-instruction discards that instruction entirely. On release, execution starts at the first enabled edge.
- cpu_en==0: all state holds, including halted. rom_adrs stays equal to pc.
- Timing: one instruction per enabled edge, with zero wait states. The architectural effects (register, out_port, pc, carry) are visible after that edge.
- Default pc update: pc <= pc+1, wrapping from 4'hF to 4'h0.
- Carry rule: ADD instructions set carry to the adder carry-out. Every other instruction, including NOPs and jumps, clears carry to 0.
- Opcodes (these encodings are fixed in defines.v):
  - 0000 ADD A,Im: A <= A+Im (4-bit), carry <= carry-out.
  - 0001 MOV A,B: A <= B.
  - 0010 IN A: A <= in_port.
  - 0011 MOV A,Im: A <= Im.
  - 0100 MOV B,A: B <= A.
  - 0101 ADD B,Im: B <= B+Im, carry <= carry-out.
  - 0110 IN B: B <= in_port.
  - 0111 MOV B,Im: B <= Im.
  - 1001 OUT B: out_port <= B.
  - 1011 OUT Im: out_port <= Im.
  - 1110 JNC Im: if carry==0 (the value before this instruction), pc <= Im; otherwise pc <= pc+1.
  - 1111 JMP Im: pc <= Im.
  - 1000, 1010, 1100, 1101 are undefined: execute as NOP (pc+1, carry cleared, no other state change).
- halted: set when JMP executes with Im==pc. Clears only on reset. The core keeps executing the self-jump, so this flag is status only.
- in_port: sampled only at the executing edge. The bench must hold it stable around that edge; no synchroniser is inside this block.
- Simultaneous events: ADD with overflow, then a following JNC, sees carry=1 and falls through. Any instruction between them clears carry.

Decomposition:
- defines.v holds the shared opcode constants (OP_ADD_A_IM ... OP_JMP_IM, including OP_MOV_*, OP_IN_*, OP_OUT_B) and the 4-bit width constant. The core uses these constants only, never literal opcodes.
- One sub-module, alu4: a 4-bit adder taking a, b and returning sum and cout. It is shared by ADD A and ADD B, with the operand muxed by the decode.
- Decode is combinational inside td4_core. Registers are a single clocked block with asynchronous active-low reset.

Test Plan:
- Reset: reset=0 asynchronously mid-cycle -> out_port=0, rom_adrs=0, halted=0 immediately. After release plus one edge with ROM word {OUT Im,0111} -> out_port=4'b0111, rom_adrs=1.
- Carry and JNC: program MOV A,3; ADD A,E; JNC 0 -> after ADD, A=1 and carry=1; JNC falls through to pc=3. Repeat with ADD A,1 -> A=4, carry=0, JNC lands pc=0.
- Register moves and I/O: in_port=4'hA; IN A; MOV B,A; ADD B,1; OUT B -> out_port=4'hB, carry=0.
- cpu_en stall: deassert cpu_en for 5 edges mid-program -> rom_adrs, out_port and all registers unchanged. Execution resumes at the same pc when cpu_en returns high.
- Halt and wrap: JMP F at address F -> halted=1 after that edge and pc stays F. Separately, a NOP (opcode 1000) at F -> pc wraps to 0, halted stays 0.
- Undefined opcode after ADD with carry=1 -> carry=0, and a following JNC is taken.
